// File: rtl/timer_v.sv
// Auto-reloading down-counter: loads data_in, counts to 1, then reloads or idles.
// cnt_one flags the terminal count and is decoded from registered state only.
module timer_v #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] cnt_out,
    input  logic             enable,
    output logic             cnt_one
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             din_zero;
    logic             at_term;

    assign din_zero = (data_in == CNT_ZERO);
    // Treat any value <= 1 as terminal so the counter can never wrap in COUNT.
    assign at_term  = (cnt_out <= CNT_ONE);

    // rst_n is active-high despite its name.
    always_ff @(posedge i_clk) begin
        if (rst_n) begin
            state   <= IDLE;
            cnt_out <= CNT_ZERO;
        end else begin
            state   <= state_nxt;
            cnt_out <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_out;
        case (state)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (enable && !din_zero) begin
                    cnt_nxt   = data_in;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (enable) begin
                    if (!at_term) begin
                        cnt_nxt = cnt_out - CNT_ONE;
                    end else if (!din_zero) begin
                        cnt_nxt = data_in;
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = CNT_ZERO;
                state_nxt = IDLE;
            end
        endcase
    end

    assign cnt_one = (state == COUNT) && (cnt_out == CNT_ONE);

endmodule

// File: tb/tb_timer_v.sv
// Directed + random stimulus for timer_v, checked against a behavioural
// model that tracks "running" and the remaining count as plain integers.
module tb_timer_v;

    localparam int W = 4;

    logic         i_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] cnt_out;
    logic         enable = 1'b0;
    logic         cnt_one;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_run = 1'b0;
    int m_cnt = 0;

    timer_v #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .cnt_out (cnt_out),
        .enable  (enable),
        .cnt_one (cnt_one)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_edge(input bit r, input bit en, input int din);
        if (r) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            if (en && din != 0) begin
                m_run = 1'b1;
                m_cnt = din;
            end
        end else if (en) begin
            if (m_cnt > 1)       m_cnt = m_cnt - 1;
            else if (din != 0)   m_cnt = din;
            else begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] exp_cnt, input logic exp_one);
        checks++;
        assert (cnt_out === exp_cnt) else begin
            errors++;
            $error("FAIL %s cnt_out: got %0d expected %0d", tag, cnt_out, exp_cnt);
        end
        checks++;
        assert (cnt_one === exp_one) else begin
            errors++;
            $error("FAIL %s cnt_one: got %0b expected %0b", tag, cnt_one, exp_one);
        end
    endtask

    // one clock: drive, edge, advance model, sample 1 time unit later
    task automatic step(input string tag, input bit r, input bit en, input int din);
        rst_n   = r;
        enable  = en;
        data_in = W'(din);
        @(posedge i_clk);
        model_edge(r, en, din);
        #1;
        check(tag, W'(m_cnt), m_run && m_cnt == 1);
    endtask

    int ones;
    int guard;

    initial begin
        // reset first; enable asserted to show reset overrides it
        step("reset0", 1'b1, 1'b1, 8);
        step("reset1", 1'b1, 1'b1, 8);
        check("reset_const", 4'd0, 1'b0);

        // continuous counting at period 8
        step("p8_first", 1'b0, 1'b1, 8);
        check("p8_load_const", 4'd8, 1'b0);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step("p8", 1'b0, 1'b1, 8);
            if (cnt_one) ones++;
        end
        checks++;
        assert (ones == 2) else begin
            errors++;
            $error("FAIL p8_ones: got %0d expected 2", ones);
        end

        // change data_in mid-count: current countdown finishes first
        for (int i = 0; i < 3; i++) step("p8to4_a", 1'b0, 1'b1, 8);
        for (int i = 0; i < 14; i++) step("p8to4_b", 1'b0, 1'b1, 4);

        // pause at 5 for 3 cycles with period 9
        guard = 0;
        while (!(m_run && m_cnt == 5) && guard < 40) begin
            step("p9_seek", 1'b0, 1'b1, 9);
            guard++;
        end
        checks++;
        assert (guard < 40) else begin
            errors++;
            $error("FAIL p9_seek_timeout: got %0d expected <40", guard);
        end
        for (int i = 0; i < 3; i++) begin
            step("pause", 1'b0, 1'b0, 9);
            check("pause_const", 4'd5, 1'b0);
        end
        for (int i = 0; i < 6; i++) step("resume", 1'b0, 1'b1, 9);

        // reset mid-count at 3, held with enable high
        guard = 0;
        while (!(m_run && m_cnt == 3) && guard < 40) begin
            step("rst_seek", 1'b0, 1'b1, 9);
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            step("rst_mid", 1'b1, 1'b1, 9);
            check("rst_mid_const", 4'd0, 1'b0);
        end

        // data_in == 0 from IDLE stays idle
        for (int i = 0; i < 3; i++) step("zero_idle", 1'b0, 1'b1, 0);
        // zero before reaching 1 returns to IDLE after the terminal count
        for (int i = 0; i < 3; i++) step("zero_run", 1'b0, 1'b1, 6);
        for (int i = 0; i < 6; i++) step("zero_end", 1'b0, 1'b1, 0);
        check("zero_end_const", 4'd0, 1'b0);

        // max period, then period 1 (flag stays high)
        for (int i = 0; i < 32; i++) step("p15", 1'b0, 1'b1, 15);
        for (int i = 0; i < 20; i++) step("p1", 1'b0, 1'b1, 1);
        check("p1_const", 4'd1, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit r, en;
            int din;
            r   = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 9) < 8);
            din = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
            step("rand", r, en, din);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
